// File: rtl/amstrad_mem_arbiter_if.sv
// Bus bundle between the motherboard (CPU/CRTC side), the arbiter and the RAM controller.
// The arbiter uses the master modport; the environment (board + RAM) uses slave.
interface amstrad_mem_arbiter_if;
  logic [22:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic        cpu_rd;
  logic        cpu_wr;
  logic [7:0]  cpu_din;
  logic        cpu_busy;
  logic [15:0] vid_addr;
  logic        vid_strobe;
  logic [7:0]  vid_din;
  logic        vid_overrun;
  logic [22:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic        ram_we;
  logic        ram_req;
  logic        ram_ack;
  logic [7:0]  ram_rdata;

  modport master (
    input  cpu_addr, cpu_dout, cpu_rd, cpu_wr, vid_addr, vid_strobe, ram_ack, ram_rdata,
    output cpu_din, cpu_busy, vid_din, vid_overrun, ram_addr, ram_wdata, ram_we, ram_req
  );

  modport slave (
    output cpu_addr, cpu_dout, cpu_rd, cpu_wr, vid_addr, vid_strobe, ram_ack, ram_rdata,
    input  cpu_din, cpu_busy, vid_din, vid_overrun, ram_addr, ram_wdata, ram_we, ram_req
  );
endinterface

// File: rtl/amstrad_mem_arbiter.sv
// Single-port RAM arbiter: CRTC video fetches (fixed priority) and CPU accesses
// merged into one req/ack stream, with an idle cycle between grants.
module amstrad_mem_arbiter #(
  parameter logic [22:0] VID_BASE = 23'h000000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  amstrad_mem_arbiter_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_VID, S_CPU} state_e;

  state_e      state_q, state_d;
  logic        cpu_act_q;
  logic        cpu_pend_q;
  logic        cpu_we_q;
  logic [22:0] cpu_addr_q;
  logic [7:0]  cpu_data_q;
  logic [7:0]  cpu_din_q;
  logic        vid_pend_q;
  logic        vid_ovr_q;
  logic [15:0] vid_addr_q;
  logic [7:0]  vid_din_q;
  logic [22:0] req_addr_q;

  logic cpu_act, cpu_rise, ack_vid, ack_cpu;

  assign cpu_act  = bus.cpu_rd | bus.cpu_wr;
  assign cpu_rise = cpu_act & ~cpu_act_q;
  assign ack_vid  = (state_q == S_VID) & bus.ram_ack;
  assign ack_cpu  = (state_q == S_CPU) & bus.ram_ack;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next state: always pass through IDLE between grants
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (vid_pend_q)      state_d = S_VID;
        else if (cpu_pend_q) state_d = S_CPU;
      end
      S_VID:   if (bus.ram_ack) state_d = S_IDLE;
      S_CPU:   if (bus.ram_ack) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: decoded from state and registers that cannot change while granted
  always_comb begin
    bus.ram_req   = (state_q != S_IDLE);
    bus.ram_we    = (state_q == S_CPU) & cpu_we_q;
    bus.ram_wdata = cpu_data_q;
    bus.ram_addr  = req_addr_q;
  end

  assign bus.cpu_din     = cpu_din_q;
  assign bus.cpu_busy    = cpu_pend_q;
  assign bus.vid_din     = vid_din_q;
  assign bus.vid_overrun = vid_ovr_q;

  // CPU side: edge-triggered latch; edges while pending are dropped
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cpu_act_q  <= 1'b0;
      cpu_pend_q <= 1'b0;
      cpu_we_q   <= 1'b0;
      cpu_addr_q <= '0;
      cpu_data_q <= '0;
      cpu_din_q  <= 8'hFF;
    end else begin
      cpu_act_q <= cpu_act;
      if (ack_cpu) begin
        cpu_pend_q <= 1'b0;
        if (!cpu_we_q) cpu_din_q <= bus.ram_rdata;
      end else if (cpu_rise && !cpu_pend_q) begin
        cpu_pend_q <= 1'b1;
        cpu_we_q   <= bus.cpu_wr;
        cpu_addr_q <= bus.cpu_addr;
        cpu_data_q <= bus.cpu_dout;
      end
    end
  end

  // Video side: latest strobe wins; a strobe in the ack cycle re-arms cleanly
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vid_pend_q <= 1'b0;
      vid_ovr_q  <= 1'b0;
      vid_addr_q <= '0;
      vid_din_q  <= 8'h00;
    end else begin
      if (ack_vid) vid_din_q <= bus.ram_rdata;
      if (bus.vid_strobe) begin
        vid_addr_q <= bus.vid_addr;
        vid_pend_q <= 1'b1;
        if (vid_pend_q && !ack_vid) vid_ovr_q <= 1'b1;
      end else if (ack_vid) begin
        vid_pend_q <= 1'b0;
      end
    end
  end

  // Grant address is frozen on leaving IDLE so late strobes cannot disturb it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_addr_q <= '0;
    end else if (state_q == S_IDLE) begin
      if (vid_pend_q)      req_addr_q <= VID_BASE + {7'b0, vid_addr_q};
      else if (cpu_pend_q) req_addr_q <= cpu_addr_q;
    end
  end

endmodule

// File: tb/tb_amstrad_mem_arbiter.sv
// Directed bench for amstrad_mem_arbiter: transaction-level model plus per-cycle compare.
module tb_amstrad_mem_arbiter;

  typedef struct {
    logic [22:0] addr;
    logic        we;
    logic [7:0]  wdata;
    logic        vid;
  } req_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  amstrad_mem_arbiter_if b0 ();
  amstrad_mem_arbiter_if b1 ();

  amstrad_mem_arbiter #(.VID_BASE(23'h000000)) u0 (.clk(clk), .reset_n(reset_n), .bus(b0));
  amstrad_mem_arbiter #(.VID_BASE(23'h7FFFF0)) u1 (.clk(clk), .reset_n(reset_n), .bus(b1));

  int n_vec = 0;
  int n_bad = 0;

  req_t       exp_q[$];
  logic [7:0] rq_data[$];
  int         ack_dly = 0;
  int         req_cyc = 0;
  logic       inj_ack = 1'b0;
  logic [7:0] inj_data = 8'h00;

  // model state
  logic       m_busy, m_vpend, m_ovr, m_prev_act;
  logic [7:0] m_cpu_din, m_vid_din;
  logic       cur_valid = 1'b0;
  req_t       cur;
  int         n_grants = 0;
  logic       ack_ev, rise_ok;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic push_req(input logic [22:0] a, input logic we, input logic [7:0] wd,
                          input logic vid, input logic [7:0] rd);
    req_t r;
    r.addr = a; r.we = we; r.wdata = wd; r.vid = vid;
    exp_q.push_back(r);
    rq_data.push_back(rd);
  endtask

  task automatic wait_idle(input string nm);
    bit done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !b0.ram_req && !b0.cpu_busy) done = 1'b1;
    end
    @(negedge clk);
    chk({nm, "_idle_timeout"}, {31'b0, done}, 32'd1);
  endtask

  task automatic wait_req(input string nm);
    bit seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (b0.ram_req) seen = 1'b1;
    end
    chk({nm, "_req_timeout"}, {31'b0, seen}, 32'd1);
  endtask

  // RAM model for u0: ack after ack_dly request cycles, data from rq_data
  always @(negedge clk) begin
    if (inj_ack) begin
      b0.ram_ack = 1'b1; b0.ram_rdata = inj_data;
    end else if (b0.ram_req) begin
      if (req_cyc == ack_dly) begin
        b0.ram_ack   = 1'b1;
        b0.ram_rdata = (rq_data.size() != 0) ? rq_data.pop_front() : 8'hEE;
      end else begin
        b0.ram_ack = 1'b0; b0.ram_rdata = 8'hEE;
      end
      req_cyc++;
    end else begin
      b0.ram_ack = 1'b0; b0.ram_rdata = 8'hEE; req_cyc = 0;
    end
  end

  // Behavioural model + per-cycle compare for u0
  always @(posedge clk) begin
    #1;
    if (!reset_n) begin
      m_busy = 1'b0; m_vpend = 1'b0; m_ovr = 1'b0; m_prev_act = 1'b0;
      m_cpu_din = 8'hFF; m_vid_din = 8'h00; cur_valid = 1'b0;
    end else begin
      ack_ev  = cur_valid && b0.ram_ack;
      rise_ok = (b0.cpu_rd | b0.cpu_wr) && !m_prev_act && !m_busy;
      m_prev_act = b0.cpu_rd | b0.cpu_wr;
      if (ack_ev) begin
        if (cur.vid) begin
          m_vid_din = b0.ram_rdata; m_vpend = 1'b0;
        end else begin
          if (!cur.we) m_cpu_din = b0.ram_rdata;
          m_busy = 1'b0;
        end
        chk("req_low_after_ack", {31'b0, b0.ram_req}, 32'd0);
        cur_valid = 1'b0;
      end
      if (rise_ok) m_busy = 1'b1;
      if (b0.vid_strobe) begin
        if (m_vpend) m_ovr = 1'b1;
        m_vpend = 1'b1;
      end
      if (b0.ram_req && !cur_valid) begin
        n_grants++;
        if (exp_q.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL unexpected_req: got addr %h we %b, expected no request", b0.ram_addr, b0.ram_we);
          cur.addr = b0.ram_addr; cur.we = b0.ram_we; cur.wdata = b0.ram_wdata; cur.vid = !b0.ram_we;
        end else begin
          cur = exp_q.pop_front();
        end
        cur_valid = 1'b1;
      end
      if (b0.ram_req) begin
        chk("ram_addr", {9'b0, b0.ram_addr}, {9'b0, cur.addr});
        chk("ram_we", {31'b0, b0.ram_we}, {31'b0, cur.we});
        if (cur.we) chk("ram_wdata", {24'b0, b0.ram_wdata}, {24'b0, cur.wdata});
        chk("req_has_work", {31'b0, !(m_busy || m_vpend)}, 32'd0);
      end else begin
        cur_valid = 1'b0;
      end
      chk("cpu_din", {24'b0, b0.cpu_din}, {24'b0, m_cpu_din});
      chk("vid_din", {24'b0, b0.vid_din}, {24'b0, m_vid_din});
      chk("cpu_busy", {31'b0, b0.cpu_busy}, {31'b0, m_busy});
      chk("vid_overrun", {31'b0, b0.vid_overrun}, {31'b0, m_ovr});
    end
  end

  initial begin
    b0.cpu_addr = '0; b0.cpu_dout = '0; b0.cpu_rd = 0; b0.cpu_wr = 0;
    b0.vid_addr = '0; b0.vid_strobe = 0; b0.ram_ack = 0; b0.ram_rdata = 8'hEE;
    b1.cpu_addr = '0; b1.cpu_dout = '0; b1.cpu_rd = 0; b1.cpu_wr = 0;
    b1.vid_addr = '0; b1.vid_strobe = 0; b1.ram_ack = 0; b1.ram_rdata = 8'hEE;

    // reset values
    repeat (3) @(negedge clk);
    chk("rst_cpu_din", {24'b0, b0.cpu_din}, 32'hFF);
    chk("rst_vid_din", {24'b0, b0.vid_din}, 32'h00);
    chk("rst_ram_req", {31'b0, b0.ram_req}, 32'd0);
    chk("rst_ram_addr", {9'b0, b0.ram_addr}, 32'd0);
    chk("rst_busy_ovr", {30'b0, b0.cpu_busy, b0.vid_overrun}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // address wrap on the high-base instance
    b1.vid_addr = 16'h0020; b1.vid_strobe = 1'b1;
    @(negedge clk); b1.vid_strobe = 1'b0;
    for (int i = 0; i < 10 && !b1.ram_req; i++) @(negedge clk);
    chk("wrap_req", {31'b0, b1.ram_req}, 32'd1);
    chk("wrap_addr", {9'b0, b1.ram_addr}, 32'h000010);
    chk("wrap_we", {31'b0, b1.ram_we}, 32'd0);
    b1.ram_ack = 1'b1; b1.ram_rdata = 8'h9E;
    @(negedge clk); b1.ram_ack = 1'b0; b1.ram_rdata = 8'hEE;
    chk("wrap_req_drop", {31'b0, b1.ram_req}, 32'd0);
    chk("wrap_vid_din", {24'b0, b1.vid_din}, 32'h9E);

    // CPU read, 4-cycle level, ack 2 cycles into the request
    ack_dly = 2;
    push_req(23'h012345, 1'b0, 8'h00, 1'b0, 8'hA5);
    b0.cpu_addr = 23'h012345; b0.cpu_dout = 8'h00; b0.cpu_rd = 1'b1;
    @(negedge clk);
    chk("rd_busy_n1", {31'b0, b0.cpu_busy}, 32'd1);
    chk("rd_req_n1", {31'b0, b0.ram_req}, 32'd0);
    @(negedge clk);
    chk("rd_req_n2", {31'b0, b0.ram_req}, 32'd1);
    chk("rd_addr_n2", {9'b0, b0.ram_addr}, 32'h012345);
    repeat (2) @(negedge clk);
    b0.cpu_rd = 1'b0;
    wait_idle("rd");
    chk("rd_cpu_din", {24'b0, b0.cpu_din}, 32'hA5);

    // CPU write held for 20 cycles: exactly one request
    ack_dly = 0;
    push_req(23'h0ABCDE, 1'b1, 8'h3C, 1'b0, 8'hEE);
    b0.cpu_addr = 23'h0ABCDE; b0.cpu_dout = 8'h3C; b0.cpu_wr = 1'b1;
    repeat (20) @(negedge clk);
    b0.cpu_wr = 1'b0;
    wait_idle("wr");
    chk("wr_cpu_din_kept", {24'b0, b0.cpu_din}, 32'hA5);

    // same-cycle CPU edge and video strobe: video first
    ack_dly = 1;
    push_req(23'h00C000, 1'b0, 8'h00, 1'b1, 8'h5A);
    push_req(23'h000777, 1'b0, 8'h00, 1'b0, 8'hC3);
    b0.vid_addr = 16'hC000; b0.vid_strobe = 1'b1;
    b0.cpu_addr = 23'h000777; b0.cpu_dout = 8'h00; b0.cpu_rd = 1'b1;
    @(negedge clk); b0.vid_strobe = 1'b0;
    @(negedge clk); b0.cpu_rd = 1'b0;
    wait_idle("prio");
    chk("prio_vid_din", {24'b0, b0.vid_din}, 32'h5A);
    chk("prio_cpu_din", {24'b0, b0.cpu_din}, 32'hC3);

    // strobe in the ack cycle of a video fetch: refetch, no overrun
    ack_dly = 3;
    push_req(23'h000040, 1'b0, 8'h00, 1'b1, 8'h33);
    push_req(23'h000080, 1'b0, 8'h00, 1'b1, 8'h44);
    b0.vid_addr = 16'h0040; b0.vid_strobe = 1'b1;
    @(negedge clk); b0.vid_strobe = 1'b0;
    wait_req("ackstb");
    repeat (3) @(negedge clk);
    b0.vid_addr = 16'h0080; b0.vid_strobe = 1'b1;
    @(negedge clk); b0.vid_strobe = 1'b0;
    wait_idle("ackstb");
    chk("ackstb_ovr", {31'b0, b0.vid_overrun}, 32'd0);
    chk("ackstb_vid_din", {24'b0, b0.vid_din}, 32'h44);

    // two strobes behind an in-flight CPU access: one fetch, latest address
    ack_dly = 6;
    push_req(23'h000100, 1'b0, 8'h00, 1'b0, 8'h11);
    push_req(23'h002000, 1'b0, 8'h00, 1'b1, 8'h22);
    b0.cpu_addr = 23'h000100; b0.cpu_dout = 8'h00; b0.cpu_rd = 1'b1;
    @(negedge clk); b0.cpu_rd = 1'b0;
    wait_req("ovr");
    b0.vid_addr = 16'h1000; b0.vid_strobe = 1'b1;
    @(negedge clk); b0.vid_strobe = 1'b0;
    @(negedge clk);
    b0.vid_addr = 16'h2000; b0.vid_strobe = 1'b1;
    @(negedge clk); b0.vid_strobe = 1'b0;
    chk("ovr_set", {31'b0, b0.vid_overrun}, 32'd1);
    wait_idle("ovr");
    repeat (5) @(negedge clk);
    chk("ovr_sticky", {31'b0, b0.vid_overrun}, 32'd1);
    chk("ovr_vid_din", {24'b0, b0.vid_din}, 32'h22);
    chk("ovr_cpu_din", {24'b0, b0.cpu_din}, 32'h11);

    // reset in the middle of a request, then a stale ack
    ack_dly = 10;
    push_req(23'h055555, 1'b0, 8'h00, 1'b0, 8'h66);
    b0.cpu_addr = 23'h055555; b0.cpu_rd = 1'b1;
    @(negedge clk); b0.cpu_rd = 1'b0;
    wait_req("mid");
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("mid_req_async", {31'b0, b0.ram_req}, 32'd0);
    chk("mid_cpu_din", {24'b0, b0.cpu_din}, 32'hFF);
    chk("mid_busy", {31'b0, b0.cpu_busy}, 32'd0);
    chk("mid_ovr", {31'b0, b0.vid_overrun}, 32'd0);
    rq_data.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #2 inj_data = 8'h77; inj_ack = 1'b1;
    @(posedge clk); #2 inj_ack = 1'b0;
    repeat (4) @(negedge clk);
    chk("stale_cpu_din", {24'b0, b0.cpu_din}, 32'hFF);
    chk("stale_vid_din", {24'b0, b0.vid_din}, 32'h00);
    chk("stale_req", {31'b0, b0.ram_req}, 32'd0);

    chk("exp_q_empty", exp_q.size(), 32'd0);
    chk("grant_count", n_grants, 32'd9);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/amstrad_mem_arbiter.md
# amstrad_mem_arbiter

Single-port memory arbiter between the Amstrad motherboard and the external RAM controller. It merges CPU memory accesses and CRTC video fetches into one request/acknowledge stream toward RAM. CPU cycles arrive on the motherboard's memory outputs; CRTC fetches arrive on its video-address output. Read data returns to the CPU data-in path and to the CRTC video-data input. Video fetches have fixed priority over CPU accesses.

## Interface
Parameters:
- VID_BASE, 23'h000000, physical base added to the 16-bit video address.

Ports:
- clk  in  1  system clock (same clock as motherboard).
- reset_n  in  1  asynchronous, active-low reset.
- cpu_addr  in  23  CPU physical address (motherboard mem_addr).
- cpu_dout  in  8  CPU write data.
- cpu_rd  in  1  CPU memory read, level.
- cpu_wr  in  1  CPU memory write, level.
- cpu_din  out  8  last CPU read data.
- cpu_busy  out  1  CPU access latched and not yet acknowledged.
- vid_addr  in  16  CRTC fetch address.
- vid_strobe  in  1  one-cycle pulse: sample vid_addr and fetch.
- vid_din  out  8  last video fetch data.
- vid_overrun  out  1  sticky: strobe arrived while a video fetch was pending.
- ram_addr  out  23  RAM address.
- ram_wdata  out  8  RAM write data.
- ram_we  out  1  write qualifier, valid while ram_req is high.
- ram_req  out  1  request, held until ram_ack.
- ram_ack  in  1  one-cycle completion; ram_rdata valid the same cycle.
- ram_rdata  in  8  RAM read data.

## Operation
- CPU edge detection: registered cpu_act = cpu_rd | cpu_wr. A 0->1 transition latches cpu_addr, cpu_dout and type (wr wins if both high) and sets cpu_pend. Holding cpu_act high never re-triggers. Deasserting before service does not cancel the access.
- A new CPU rising edge while cpu_pend is set is ignored.
- vid_strobe latches vid_addr and sets vid_pend. If vid_pend is already set, the address is overwritten (latest wins) and vid_overrun is set. vid_overrun clears only on reset.
- FSM states are IDLE, VID, CPU.
  - IDLE: if vid_pend, go to VID. Otherwise, if cpu_pend, go to CPU.
  - VID: ram_req=1, ram_we=0, ram_addr = VID_BASE + vid_addr (23-bit, modulo 2^23). On ram_ack, vid_din <= ram_rdata, clear vid_pend, go to IDLE.
  - CPU: ram_req=1, ram_addr = latched address, ram_we = latched type, ram_wdata = latched data. On ram_ack: for a read, cpu_din <= ram_rdata. Clear cpu_pend, go to IDLE.
- Request outputs are taken from registers. ram_addr, ram_we and ram_wdata are stable for the whole time ram_req is high.
- cpu_busy = cpu_pend. This includes the cycle the edge is latched, so it is high from the cycle after the edge through the ack cycle.
- A strobe in the ack cycle of a VID fetch sets vid_pend again and does not flag an overrun.
- ram_ack in IDLE is ignored.
- Reset values: all outputs 0, cpu_din = 8'hFF, vid_din = 8'h00, FSM in IDLE, pending flags cleared.
- Reset mid-access: ram_req drops asynchronously. A stale ram_ack after release, arriving in IDLE, is ignored.

## Timing
- Edge/strobe at cycle N: the pending flag is set at edge N+1. FSM leaves IDLE at N+2, and ram_req is high from N+2.
- Ack at cycle M: data is registered at edge M+1, and ram_req is low at M+1.
- The FSM returns to IDLE for one cycle between grants, so there are never back-to-back requests without a gap.
- Minimum turnaround with a zero-wait RAM (ack in the first request cycle): 3 cycles per access.
- The arbiter is not preemptive. A pending video fetch waits for an in-flight CPU access to finish, then takes the next grant.

## Test plan
- CPU read: cpu_addr=23'h012345, pulse cpu_rd for 4 cycles; RAM acks 2 cycles after req with rdata=8'hA5 -> exactly one request, addr 012345, ram_we=0; cpu_din=8'hA5; cpu_busy falls after the ack.
- CPU write held: cpu_wr high for 20 cycles, data 8'h3C -> exactly one ram_we=1 request with wdata 3C; no retrigger.
- Priority: cpu_rd edge and vid_strobe (vid_addr=16'hC000, VID_BASE=0) in the same cycle -> first grant is VID at addr 00C000, then CPU; vid_din and cpu_din get the respective rdata.
- Overrun: two strobes (addr 1000 then 2000) before the first grant -> a single fetch at 002000; vid_overrun=1 and stays 1.
- Reset mid-access: assert reset_n=0 while ram_req=1 -> ram_req=0 immediately, cpu_din=FF; an ack after release causes no state change and no data update.
- Wrap: VID_BASE=23'h7FFFF0, vid_addr=16'h0020 -> ram_addr=23'h000010.
